psram_cmd_scheduler: RTL and testbench
======================================

// Module: psram_cmd_scheduler
// PURPOSE
//  Sequences PSRAM accesses requested by the UART command parser (R/W frames decoded to addr+data).
//  Queues commands, issues them one at a time to the PSRAM controller with a req/ack/done handshake,
//  enforces a recovery gap between accesses, and forwards read data to the UART transmitter.
//  Sits between uart (RX decode / TX return path) and the PSRAM controller in the top level.
// PARAMETERS
//  ADDR_WIDTH      24    PSRAM word address width
//  DATA_WIDTH      16    PSRAM data width
//  FIFO_DEPTH      4     command queue entries (power of 2, >=2)
//  TIMEOUT_CYCLES  1024  max cycles from psram_ack to psram_done before abort
//  GAP_CYCLES      2     idle cycles between consecutive PSRAM accesses (CE# recovery)
// PORTS
//  sys_clk          in   1    system clock (27 MHz)
//  sys_rst_n        in   1    asynchronous active-low reset
//  cmd_valid        in   1    UART parser has a decoded command
//  cmd_ready        out  1    queue can accept; transfer when cmd_valid&&cmd_ready
//  cmd_write        in   1    1=write, 0=read
//  cmd_addr         in   ADDR_WIDTH  target address
//  cmd_wdata        in   DATA_WIDTH  write data (ignored for reads)
//  psram_init_done  in   1    PSRAM controller calibrated/ready
//  psram_req        out  1    access request, held until psram_ack
//  psram_write      out  1    access type, stable while psram_req
//  psram_addr       out  ADDR_WIDTH  stable while psram_req
//  psram_wdata      out  DATA_WIDTH  stable while psram_req
//  psram_ack        in   1    one-cycle: controller accepted request
//  psram_done       in   1    one-cycle: access complete; psram_rdata valid this cycle
//  psram_rdata      in   DATA_WIDTH  read data
//  tx_start         out  1    one-cycle pulse: transmit tx_data
//  tx_data          out  DATA_WIDTH  read data for UART TX, held from tx_start until next tx_start
//  tx_busy          in   1    UART transmitter busy
//  busy             out  1    high in any state except S_IDLE with empty queue
//  err_timeout      out  1    one-cycle pulse on access abort
//  err_count        out  8    saturating count of timeouts
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, state S_INIT, except cmd_ready=0 (follows queue after reset).
//  Queue: synchronous FIFO of {write,addr,wdata}; cmd_ready = (count<FIFO_DEPTH), no bypass.
//   Push and pop in same cycle legal at any fill; count unchanged. Full: cmd_ready=0, input ignored.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM:
//   S_INIT : wait psram_init_done=1 -> S_IDLE. Commands may queue meanwhile.
//   S_IDLE : if queue non-empty && psram_init_done: pop head into issue regs, -> S_ISSUE.
//   S_ISSUE: psram_req=1 with stable write/addr/wdata; on psram_ack -> S_WAIT (req low next cycle).
//   S_WAIT : timer counts from 0; on psram_done: read -> capture psram_rdata, -> S_RESP;
//            write -> S_GAP. Timer reaches TIMEOUT_CYCLES-1 without done: pulse err_timeout,
//            err_count++ (saturates at 255), drop command, -> S_GAP.
//   S_RESP : when tx_busy=0, pulse tx_start one cycle with tx_data = captured rdata, -> S_GAP.
//   S_GAP  : count GAP_CYCLES cycles, -> S_IDLE.
//  Latency: cmd accepted at edge N -> psram_req high from edge N+2 (empty queue, idle, init done).
//  psram_done in S_ISSUE or S_IDLE ignored (protocol error, no state change).
//  psram_init_done checked only in S_INIT/S_IDLE; deassertion mid-access does not abort.
//  psram_ack and psram_done in the same cycle while in S_ISSUE: treat as ack then done in the
//   same cycle; go directly to S_RESP (read) or S_GAP (write).
//  Reset mid-access: psram_req drops asynchronously, queue flushed, in-flight command lost.
//  Timer and gap counters sized $clog2 of their parameter + 1; no wrap.
// STRUCTURE
//  psram_sched_pkg: state encoding localparams (S_INIT..S_GAP), command-entry field widths.
//  Sub-module: psram_cmd_fifo (parameterised sync FIFO, count output); FSM, timer, tx return in top.
// TESTING
//  1. Write 0x1234 @0x000010 on empty idle queue -> psram_req at cycle N+2, write=1, addr/wdata stable
//     until ack; no tx_start.
//  2. Read @0x0000AB, controller returns 0xBEEF after 20 cycles -> one tx_start, tx_data=0xBEEF;
//     with tx_busy held 100 cycles, tx_start waits until tx_busy=0.
//  3. Push 5 commands back-to-back with ack stalled -> 4 accepted (cmd_ready=0 on 5th), then issued
//     in order with >=GAP_CYCLES idle between req deassert and next req.
//  4. Never assert psram_done -> err_timeout pulse exactly 1024 cycles after ack, err_count=1,
//     next queued command issued; 300 timeouts -> err_count=255.
//  5. Commands pushed before psram_init_done -> no psram_req until init_done=1, then FIFO order kept.
//  6. sys_rst_n low during S_WAIT -> psram_req/tx_start/busy 0 immediately, queue empty after release.

Source files
------------

// File: rtl/psram_sched_pkg.sv
// Shared definitions for the PSRAM command scheduler: state encoding,
// command-entry layout and small arithmetic helpers.
package psram_sched_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_GAP   = 3'd5
    } sched_state_e;

    // Command entry is {write, addr, wdata}; the write flag is a single bit.
    localparam int CMD_WRITE_W = 1;

    function automatic int entry_width(input int addr_w, input int data_w);
        return CMD_WRITE_W + addr_w + data_w;
    endfunction

    // Increment an 8-bit counter, holding at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psram_cmd_fifo.sv
// Synchronous command queue. Accepts only while not full (registered ready),
// head is presented combinationally from the read pointer, pointers wrap
// naturally because DEPTH is a power of two.
module psram_cmd_fifo
    import psram_sched_pkg::*;
#(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             push_s, pop_s;

    assign push_s = push && ready_q;
    assign pop_s  = pop && (count_q != {CW{1'b0}});

    // Next pointer, occupancy and ready computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CW'(DEPTH));
    end

    // Pointer / occupancy registers; ready stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign ready = ready_q;
    assign count = count_q;

endmodule

// File: rtl/psram_cmd_scheduler.sv
// Queues decoded UART R/W commands and issues them one at a time to the
// PSRAM controller (req/ack/done), with an access timeout, a CE# recovery
// gap between accesses, and read data returned to the UART transmitter.
module psram_cmd_scheduler
    import psram_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  psram_init_done,
    output logic                  psram_req,
    output logic                  psram_write,
    output logic [ADDR_WIDTH-1:0] psram_addr,
    output logic [DATA_WIDTH-1:0] psram_wdata,
    input  logic                  psram_ack,
    input  logic                  psram_done,
    input  logic [DATA_WIDTH-1:0] psram_rdata,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [7:0]            err_count
);

    localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    sched_state_e          state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  req_q, req_d;
    logic                  iss_write_q, iss_write_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_WIDTH-1:0] iss_wdata_q, iss_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  err_to_q, err_to_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  pop_s;
    logic [EW-1:0]         head_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_empty_s;

    psram_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (cmd_valid),
        .din   ({cmd_write, cmd_addr, cmd_wdata}),
        .pop   (pop_s),
        .dout  (head_s),
        .ready (cmd_ready),
        .count (fifo_count_s)
    );

    assign fifo_empty_s = (fifo_count_s == {CW{1'b0}});

    // Next-state, counters and output pulses of the access sequencer.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        req_d       = 1'b0;
        pop_s       = 1'b0;
        iss_write_d = iss_write_q;
        iss_addr_d  = iss_addr_q;
        iss_wdata_d = iss_wdata_q;
        rdata_d     = rdata_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        err_to_d    = 1'b0;
        err_cnt_d   = err_cnt_q;
        busy_d      = !((state_q == S_IDLE) && fifo_empty_s);
        case (state_q)
            S_INIT: begin
                if (psram_init_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_IDLE: begin
                if (!fifo_empty_s && psram_init_done) begin
                    pop_s       = 1'b1;
                    iss_write_d = head_s[EW-1];
                    iss_addr_d  = head_s[EW-2 -: ADDR_WIDTH];
                    iss_wdata_d = head_s[DATA_WIDTH-1:0];
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // An ack only counts once the request is visible; a done
                // arriving with the ack completes the access immediately.
                if (req_q && psram_ack) begin
                    timer_d = {TW{1'b0}};
                    if (!psram_done) begin
                        state_d = S_WAIT;
                    end else if (iss_write_q) begin
                        gap_d   = {GW{1'b0}};
                        state_d = S_GAP;
                    end else begin
                        rdata_d = psram_rdata;
                        state_d = S_RESP;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (psram_done) begin
                    if (iss_write_q) begin
                        gap_d   = {GW{1'b0}};
                        state_d = S_GAP;
                    end else begin
                        rdata_d = psram_rdata;
                        state_d = S_RESP;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_to_d  = 1'b1;
                    err_cnt_d = sat_inc8(err_cnt_q);
                    gap_d     = {GW{1'b0}};
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rdata_q;
                    gap_d      = {GW{1'b0}};
                    state_d    = S_GAP;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers; reset drops the request immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_INIT;
            timer_q     <= {TW{1'b0}};
            gap_q       <= {GW{1'b0}};
            req_q       <= 1'b0;
            iss_write_q <= 1'b0;
            iss_addr_q  <= {ADDR_WIDTH{1'b0}};
            iss_wdata_q <= {DATA_WIDTH{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            tx_start_q  <= 1'b0;
            tx_data_q   <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            req_q       <= req_d;
            iss_write_q <= iss_write_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;
            rdata_q     <= rdata_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            err_to_q    <= err_to_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign psram_req   = req_q;
    assign psram_write = iss_write_q;
    assign psram_addr  = iss_addr_q;
    assign psram_wdata = iss_wdata_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// Directed self-checking bench for psram_cmd_scheduler. A second instance
// with a short timeout and an always-acking controller covers counter
// saturation within a reasonable run time.
module tb_psram_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        init_done;
    logic        psram_req, psram_write;
    logic [23:0] psram_addr;
    logic [15:0] psram_wdata;
    logic        psram_ack, psram_done;
    logic [15:0] psram_rdata;
    logic        tx_start, tx_busy, busy, err_timeout;
    logic [15:0] tx_data;
    logic [7:0]  err_count;

    logic        rst2_n;
    logic        ready2, req2, wr2, tx_start2, busy2, err_to2;
    logic [23:0] addr2;
    logic [15:0] wdata2, tx_data2;
    logic [7:0]  err_count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    psram_cmd_scheduler dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .psram_init_done(init_done),
        .psram_req(psram_req), .psram_write(psram_write), .psram_addr(psram_addr),
        .psram_wdata(psram_wdata), .psram_ack(psram_ack), .psram_done(psram_done),
        .psram_rdata(psram_rdata), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .busy(busy), .err_timeout(err_timeout), .err_count(err_count)
    );

    psram_cmd_scheduler #(.TIMEOUT_CYCLES(16)) dut_sat (
        .sys_clk(clk), .sys_rst_n(rst2_n),
        .cmd_valid(1'b1), .cmd_ready(ready2), .cmd_write(1'b1),
        .cmd_addr(24'h00ABCD), .cmd_wdata(16'h0F0F), .psram_init_done(1'b1),
        .psram_req(req2), .psram_write(wr2), .psram_addr(addr2),
        .psram_wdata(wdata2), .psram_ack(req2), .psram_done(1'b0),
        .psram_rdata(16'h0000), .tx_start(tx_start2), .tx_data(tx_data2),
        .tx_busy(1'b0), .busy(busy2), .err_timeout(err_to2), .err_count(err_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic w, input logic [23:0] a, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (psram_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (psram_req) ok = 1'b1;
    endtask

    task automatic ack_pulse();
        psram_ack = 1'b1; tick(); psram_ack = 1'b0;
    endtask

    task automatic done_pulse(input logic [15:0] d);
        psram_done = 1'b1; psram_rdata = d; tick();
        psram_done = 1'b0; psram_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        settle(3);
        n_checks++;
        if ({psram_req, tx_start, busy, err_timeout, cmd_ready, err_count} !== 13'd0)
            $display("FAIL reset_outputs: got req=%b tx=%b busy=%b err=%b rdy=%b cnt=%0d, expected all 0",
                     psram_req, tx_start, busy, err_timeout, cmd_ready, err_count);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_init_hold();
        bit seen;
        bit ok;
        push(1'b1, 24'h000100, 16'h1111);
        push(1'b1, 24'h000200, 16'h2222);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (psram_req) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL init_hold_no_req: got req seen=%b expected 0", seen);
        else n_pass++;
        init_done = 1'b1;
        wait_req(20, ok);
        n_checks++;
        if ({ok, psram_addr, psram_wdata} !== {1'b1, 24'h000100, 16'h1111})
            $display("FAIL init_first: got ok=%b addr=%h data=%h expected 1 000100 1111", ok, psram_addr, psram_wdata);
        else n_pass++;
        ack_pulse(); done_pulse(16'h0000);
        wait_req(20, ok);
        n_checks++;
        if ({ok, psram_addr, psram_wdata} !== {1'b1, 24'h000200, 16'h2222})
            $display("FAIL init_second: got ok=%b addr=%h data=%h expected 1 000200 2222", ok, psram_addr, psram_wdata);
        else n_pass++;
        ack_pulse(); done_pulse(16'h0000);
    endtask

    task automatic test_write();
        bit saw_tx;
        settle(10);
        push(1'b1, 24'h000010, 16'h1234);
        n_checks++;
        if (psram_req !== 1'b0) $display("FAIL write_lat_n0: got %b expected 0", psram_req);
        else n_pass++;
        tick();
        n_checks++;
        if (psram_req !== 1'b0) $display("FAIL write_lat_n1: got %b expected 0", psram_req);
        else n_pass++;
        tick();
        n_checks++;
        if ({psram_req, psram_write, psram_addr, psram_wdata} !== {1'b1, 1'b1, 24'h000010, 16'h1234})
            $display("FAIL write_lat_n2: got req=%b w=%b addr=%h data=%h expected 1 1 000010 1234",
                     psram_req, psram_write, psram_addr, psram_wdata);
        else n_pass++;
        settle(3);
        n_checks++;
        if ({psram_req, psram_write, psram_addr, psram_wdata} !== {1'b1, 1'b1, 24'h000010, 16'h1234})
            $display("FAIL write_stable: got req=%b w=%b addr=%h data=%h expected 1 1 000010 1234",
                     psram_req, psram_write, psram_addr, psram_wdata);
        else n_pass++;
        ack_pulse();
        n_checks++;
        if (psram_req !== 1'b0) $display("FAIL write_req_drop: got %b expected 0", psram_req);
        else n_pass++;
        settle(4);
        done_pulse(16'hFFFF);
        saw_tx = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (tx_start) saw_tx = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_tx !== 1'b0) $display("FAIL write_no_tx: got tx_start seen=%b expected 0", saw_tx);
        else n_pass++;
    endtask

    task automatic test_read();
        bit ok;
        int n_tx;
        settle(10);
        tx_busy = 1'b1;
        push(1'b0, 24'h0000AB, 16'h0000);
        wait_req(20, ok);
        n_checks++;
        if ({ok, psram_write, psram_addr} !== {1'b1, 1'b0, 24'h0000AB})
            $display("FAIL read_issue: got ok=%b w=%b addr=%h expected 1 0 0000ab", ok, psram_write, psram_addr);
        else n_pass++;
        ack_pulse();
        settle(19);
        done_pulse(16'hBEEF);
        n_tx = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_start) n_tx++;
            tick();
        end
        n_checks++;
        if (n_tx !== 0) $display("FAIL read_tx_blocked: got %0d pulses expected 0", n_tx);
        else n_pass++;
        tx_busy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if ({ok, tx_data} !== {1'b1, 16'hBEEF})
            $display("FAIL read_tx_start: got seen=%b data=%h expected 1 beef", ok, tx_data);
        else n_pass++;
        tick();
        n_checks++;
        if ({tx_start, tx_data} !== {1'b0, 16'hBEEF})
            $display("FAIL read_tx_pulse: got tx_start=%b data=%h expected 0 beef", tx_start, tx_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [4:0] acc;
        int idle;
        settle(10);
        push(1'b1, 24'h0002FF, 16'h0BAD);
        wait_req(20, ok);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1;
            cmd_addr  = 24'h000300 + 24'(i);
            cmd_wdata = 16'hA000 + 16'(i);
            acc[i] = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (acc !== 5'b01111) $display("FAIL b2b_accept: got %b expected 01111", acc);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            ack_pulse();
            done_pulse(16'h0000);
            idle = 2;
            while (!psram_req && idle < 60) begin
                idle++;
                tick();
            end
            n_checks++;
            if ({psram_req, psram_write, psram_addr, psram_wdata} !== {1'b1, 1'b1, 24'h000300 + 24'(k), 16'hA000 + 16'(k)})
                $display("FAIL b2b_order%0d: got req=%b addr=%h data=%h expected 1 %h %h",
                         k, psram_req, psram_addr, psram_wdata, 24'h000300 + 24'(k), 16'hA000 + 16'(k));
            else n_pass++;
            n_checks++;
            if (idle < 2) $display("FAIL b2b_gap%0d: got %0d idle cycles expected >= 2", k, idle);
            else n_pass++;
        end
        ack_pulse();
        done_pulse(16'h0000);
        wait_req(20, ok);
        n_checks++;
        if (ok !== 1'b0) $display("FAIL b2b_fifth_dropped: got req=%b expected 0", ok);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        settle(10);
        push(1'b0, 24'h000400, 16'h0000);
        push(1'b1, 24'h000401, 16'h5555);
        wait_req(20, ok);
        done_pulse(16'h1111);
        n_checks++;
        if ({psram_req, psram_addr} !== {1'b1, 24'h000400})
            $display("FAIL done_in_issue_ignored: got req=%b addr=%h expected 1 000400", psram_req, psram_addr);
        else n_pass++;
        ack_pulse();
        n = 0;
        while (n < 1100) begin
            tick();
            n++;
            if (err_timeout) break;
        end
        n_checks++;
        if (n !== 1024) $display("FAIL timeout_latency: got %0d cycles expected 1024", n);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'd1) $display("FAIL timeout_count: got %0d expected 1", err_count);
        else n_pass++;
        tick();
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL timeout_pulse_width: got %b expected 0", err_timeout);
        else n_pass++;
        wait_req(20, ok);
        n_checks++;
        if ({ok, psram_write, psram_addr, psram_wdata} !== {1'b1, 1'b1, 24'h000401, 16'h5555})
            $display("FAIL timeout_next_cmd: got ok=%b w=%b addr=%h data=%h expected 1 1 000401 5555",
                     ok, psram_write, psram_addr, psram_wdata);
        else n_pass++;
        ack_pulse();
        done_pulse(16'h0000);
    endtask

    task automatic test_ack_done_same_cycle();
        bit ok;
        settle(10);
        push(1'b0, 24'h000500, 16'h0000);
        wait_req(20, ok);
        psram_ack = 1'b1; psram_done = 1'b1; psram_rdata = 16'hCAFE;
        tick();
        psram_ack = 1'b0; psram_done = 1'b0; psram_rdata = 16'h0000;
        tick();
        n_checks++;
        if ({psram_req, tx_start, tx_data} !== {1'b0, 1'b1, 16'hCAFE})
            $display("FAIL ack_done_read: got req=%b tx=%b data=%h expected 0 1 cafe", psram_req, tx_start, tx_data);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int n;
        bit seen;
        rst2_n = 1'b1;
        n = 0;
        while (err_count2 != 8'd255 && n < 8000) begin
            tick();
            n++;
        end
        n_checks++;
        if (err_count2 !== 8'd255) $display("FAIL sat_reach: got %0d expected 255", err_count2);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (err_to2) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if ({seen, err_count2} !== {1'b1, 8'd255})
            $display("FAIL sat_hold: got pulse=%b count=%0d expected 1 255", seen, err_count2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        settle(10);
        push(1'b0, 24'h000600, 16'h0000);
        push(1'b0, 24'h000601, 16'h0000);
        wait_req(20, ok);
        ack_pulse();
        settle(3);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({psram_req, tx_start, busy, cmd_ready} !== 4'b0000)
            $display("FAIL rst_mid_async: got req=%b tx=%b busy=%b rdy=%b expected 0000",
                     psram_req, tx_start, busy, cmd_ready);
        else n_pass++;
        settle(2);
        rst_n = 1'b1;
        wait_req(25, ok);
        n_checks++;
        if ({ok, busy, cmd_ready} !== 3'b001)
            $display("FAIL rst_mid_flushed: got req=%b busy=%b rdy=%b expected 0 0 1", ok, busy, cmd_ready);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 24'h0; cmd_wdata = 16'h0;
        init_done = 1'b0; psram_ack = 1'b0; psram_done = 1'b0; psram_rdata = 16'h0;
        tx_busy = 1'b0;
        test_reset();
        test_init_hold();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_ack_done_same_cycle();
        test_saturate();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
